// File: rtl/fp_trace_if.sv
// Snoop/trace bundle for fp_trace_writer: fp_unit request and response taps plus the record word stream.
// master = trace writer side, slave = fp_unit taps and trace sink side.
interface fp_trace_if;
   logic        req_enable;
   logic [31:0] req_data1;
   logic [31:0] req_data2;
   logic [31:0] req_data3;
   logic        req_fmadd;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_flags;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready;

   modport master (
      input  req_enable, req_data1, req_data2, req_data3, req_fmadd,
      input  rsp_ready, rsp_result, rsp_flags,
      input  out_ready,
      output out_valid, out_data, out_last
   );

   modport slave (
      output req_enable, req_data1, req_data2, req_data3, req_fmadd,
      output rsp_ready, rsp_result, rsp_flags,
      output out_ready,
      input  out_valid, out_data, out_last
   );
endinterface

// File: rtl/fp_trace_writer.sv
// Matches fp_unit requests to responses in order and serialises each completed operation into 4/5-word hex records.
// Optional FP_TRACE_NAN_CANON_EN: every NaN result is emitted as the canonical quiet NaN 32'h7FC00000.
//
// state | meaning
// IDLE  | no record pending, out_valid low
// W_D1  | presenting operand A
// W_D2  | presenting operand B
// W_D3  | presenting operand C (mulAdd records only)
// W_RES | presenting the result word
// W_FLG | presenting the flags word, out_last high; acceptance retires the record
module fp_trace_writer #(
    parameter int REQ_DEPTH = 8,
    parameter int REC_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    fp_trace_if.master   tr,
    output logic         overflow,
    output logic         orphan,
    output logic [15:0]  rec_count
);

    localparam int REQ_AW = $clog2(REQ_DEPTH);
    localparam int REC_AW = $clog2(REC_DEPTH);

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] data3;
        logic        fmadd;
    } req_t;

    typedef struct packed {
        req_t        req;
        logic [31:0] result;
        logic [4:0]  flags;
    } rec_t;

    typedef enum logic [2:0] {IDLE, W_D1, W_D2, W_D3, W_RES, W_FLG} state_t;

    req_t   req_mem [REQ_DEPTH];
    rec_t   rec_mem [REC_DEPTH];
    logic [REQ_AW:0] req_wr, req_rd;
    logic [REC_AW:0] rec_wr, rec_rd, rec_level;
    logic   req_full, req_empty, rec_full, rec_empty;
    logic   req_push, req_pop, rec_push, rec_drop, rec_pop, rec_pending;
    req_t   req_head, req_in;
    rec_t   rec_head;
    logic [31:0] result_word;
    state_t state, state_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign req_empty = (req_wr == req_rd);
    assign req_full  = (req_wr[REQ_AW] != req_rd[REQ_AW]) &&
                       (req_wr[REQ_AW-1:0] == req_rd[REQ_AW-1:0]);
    assign rec_empty = (rec_wr == rec_rd);
    assign rec_full  = (rec_wr[REC_AW] != rec_rd[REC_AW]) &&
                       (rec_wr[REC_AW-1:0] == rec_rd[REC_AW-1:0]);
    assign rec_level = rec_wr - rec_rd;

    assign req_in   = '{data1: tr.req_data1, data2: tr.req_data2,
                        data3: tr.req_data3, fmadd: tr.req_fmadd};
    assign req_head = req_mem[req_rd[REQ_AW-1:0]];
    assign rec_head = rec_mem[rec_rd[REC_AW-1:0]];

    // Full/empty are judged on the pre-edge occupancy, so a same-cycle request cannot satisfy its own response.
    assign req_push    = tr.req_enable && !req_full;
    assign req_pop     = tr.rsp_ready && !req_empty;
    assign rec_push    = req_pop && !rec_full;
    assign rec_drop    = req_pop && rec_full;
    assign rec_pop     = (state == W_FLG) && tr.out_ready;
    assign rec_pending = (rec_level > (REC_AW+1)'(1)) || rec_push;

`ifdef FP_TRACE_NAN_CANON_EN
    assign result_word = ((rec_head.result[30:23] == 8'hFF) && (rec_head.result[22:0] != 23'd0))
                         ? 32'h7FC0_0000 : rec_head.result;
`else
    assign result_word = rec_head.result;
`endif

    always_ff @(posedge clock) begin
        if (req_push)
            req_mem[req_wr[REQ_AW-1:0]] <= req_in;
        if (rec_push)
            rec_mem[rec_wr[REC_AW-1:0]] <= '{req: req_head, result: tr.rsp_result, flags: tr.rsp_flags};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            req_wr    <= '0;
            req_rd    <= '0;
            rec_wr    <= '0;
            rec_rd    <= '0;
            state     <= IDLE;
            overflow  <= 1'b0;
            orphan    <= 1'b0;
            rec_count <= '0;
        end else begin
            state <= state_next;
            if (req_push)
                req_wr <= req_wr + 1'b1;
            if (req_pop)
                req_rd <= req_rd + 1'b1;
            if (rec_push)
                rec_wr <= rec_wr + 1'b1;
            if (rec_pop) begin
                rec_rd    <= rec_rd + 1'b1;
                rec_count <= rec_count + 16'd1;
            end
            if ((tr.req_enable && req_full) || rec_drop)
                overflow <= 1'b1;
            if (tr.rsp_ready && req_empty)
                orphan <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        tr.out_valid = 1'b0;
        tr.out_data  = 32'd0;
        tr.out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (!rec_empty)
                    state_next = W_D1;
            end
            W_D1: begin
                tr.out_valid = 1'b1;
                tr.out_data  = rec_head.req.data1;
                if (tr.out_ready)
                    state_next = W_D2;
            end
            W_D2: begin
                tr.out_valid = 1'b1;
                tr.out_data  = rec_head.req.data2;
                if (tr.out_ready)
                    state_next = rec_head.req.fmadd ? W_D3 : W_RES;
            end
            W_D3: begin
                tr.out_valid = 1'b1;
                tr.out_data  = rec_head.req.data3;
                if (tr.out_ready)
                    state_next = W_RES;
            end
            W_RES: begin
                tr.out_valid = 1'b1;
                tr.out_data  = result_word;
                if (tr.out_ready)
                    state_next = W_FLG;
            end
            W_FLG: begin
                tr.out_valid = 1'b1;
                tr.out_data  = {27'd0, rec_head.flags};
                tr.out_last  = 1'b1;
                if (tr.out_ready)
                    state_next = rec_pending ? W_D1 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_trace_writer.sv
// Scoreboard bench for fp_trace_writer: directed requests/responses queue expected words; a monitor checks every accepted word.
module tb_fp_trace_writer;

   logic        clock = 1'b0;
   logic        reset;
   logic        overflow, orphan;
   logic [15:0] rec_count;

   fp_trace_if tr();

   fp_trace_writer #(.REQ_DEPTH(8), .REC_DEPTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .tr        (tr),
      .overflow  (overflow),
      .orphan    (orphan),
      .rec_count (rec_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] d3;
      logic        fm;
   } mreq_t;

   exp_t  sb[$];
   mreq_t mq[$];
   int    checks = 0;
   int    errors = 0;

   logic        held_v = 1'b0;
   logic [31:0] held_d;
   logic        held_l;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every accepted word against the scoreboard and checks stall stability.
   always @(negedge clock) begin
      if (reset !== 1'b1) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            checks++;
            if (tr.out_valid !== 1'b1 || tr.out_data !== held_d || tr.out_last !== held_l) begin
               errors++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                        tr.out_valid, tr.out_data, tr.out_last, held_d, held_l);
            end
         end
         if (tr.out_valid === 1'b1 && tr.out_ready === 1'b1) begin
            held_v = 1'b0;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got %h expected no word", tr.out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (tr.out_data !== e.data || tr.out_last !== e.last) begin
                  errors++;
                  $display("FAIL word: got %h last=%b expected %h last=%b",
                           tr.out_data, tr.out_last, e.data, e.last);
               end
            end
         end else if (tr.out_valid === 1'b1) begin
            held_v = 1'b1;
            held_d = tr.out_data;
            held_l = tr.out_last;
         end else begin
            held_v = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic fm);
      mreq_t m;
      tr.req_enable = 1'b1;
      tr.req_data1  = a;
      tr.req_data2  = b;
      tr.req_data3  = c;
      tr.req_fmadd  = fm;
      tick();
      tr.req_enable = 1'b0;
      m = '{d1: a, d2: b, d3: c, fm: fm};
      if (mq.size() < 8)
         mq.push_back(m);
   endtask

   // exp_res is the hand-computed word the DUT must emit for this result.
   task automatic send_rsp(input logic [31:0] res, input logic [4:0] flags, input logic [31:0] exp_res);
      mreq_t m;
      tr.rsp_ready  = 1'b1;
      tr.rsp_result = res;
      tr.rsp_flags  = flags;
      tick();
      tr.rsp_ready = 1'b0;
      if (mq.size() != 0) begin
         m = mq.pop_front();
         sb.push_back('{data: m.d1, last: 1'b0});
         sb.push_back('{data: m.d2, last: 1'b0});
         if (m.fm)
            sb.push_back('{data: m.d3, last: 1'b0});
         sb.push_back('{data: exp_res, last: 1'b0});
         sb.push_back('{data: {27'd0, flags}, last: 1'b1});
      end
   endtask

   task automatic wait_drain(input int max_cycles);
      int n = 0;
      while ((sb.size() != 0 || tr.out_valid === 1'b1) && n < max_cycles) begin
         tick();
         n++;
      end
      chk("drain_done", (n < max_cycles) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      sb.delete();
      mq.delete();
   endtask

   logic [31:0] nan_exp;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef FP_TRACE_NAN_CANON_EN
      nan_exp = 32'h7FC0_0000;
`else
      nan_exp = 32'hFFC1_2345;
`endif
      reset = 1'b0;
      tr.req_enable = 1'b0;
      tr.req_data1  = '0;
      tr.req_data2  = '0;
      tr.req_data3  = '0;
      tr.req_fmadd  = 1'b0;
      tr.rsp_ready  = 1'b0;
      tr.rsp_result = '0;
      tr.rsp_flags  = '0;
      tr.out_ready  = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", {31'd0, tr.out_valid}, 32'd0);
      chk("rst_out_data", tr.out_data, 32'd0);
      chk("rst_out_last", {31'd0, tr.out_last}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_orphan", {31'd0, orphan}, 32'd0);
      chk("rst_rec_count", {16'd0, rec_count}, 32'd0);
      reset = 1'b1;
      tick();

      // add, response 3 cycles after the request, words on 4 consecutive cycles
      send_req(32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0);
      repeat (2) tick();
      send_rsp(32'h4040_0000, 5'h00, 32'h4040_0000);
      repeat (5) tick();
      chk("add_words_left", sb.size(), 32'd0);
      chk("add_rec_count", {16'd0, rec_count}, 32'd1);
      chk("add_idle", {31'd0, tr.out_valid}, 32'd0);

      // fmadd, 5-word record
      send_req(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
      repeat (2) tick();
      send_rsp(32'h4000_0000, 5'h01, 32'h4000_0000);
      repeat (6) tick();
      chk("fma_words_left", sb.size(), 32'd0);
      chk("fma_rec_count", {16'd0, rec_count}, 32'd2);

      // 3 back-to-back records with a toggling sink
      send_req(32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0);
      send_req(32'h4040_0000, 32'h4080_0000, 32'h0, 1'b0);
      send_req(32'h40A0_0000, 32'h40C0_0000, 32'h0, 1'b0);
      send_rsp(32'h4040_0000, 5'h00, 32'h4040_0000);
      send_rsp(32'h40E0_0000, 5'h01, 32'h40E0_0000);
      send_rsp(32'h4130_0000, 5'h00, 32'h4130_0000);
      begin
         int n = 0;
         while ((sb.size() != 0 || tr.out_valid === 1'b1) && n < 80) begin
            tr.out_ready = ~tr.out_ready;
            tick();
            n++;
         end
         chk("toggle_drain_done", (n < 80) ? 32'd1 : 32'd0, 32'd1);
      end
      tr.out_ready = 1'b1;
      chk("toggle_rec_count", {16'd0, rec_count}, 32'd5);

      // request FIFO overflow on the 9th request
      for (int i = 1; i <= 8; i++)
         send_req(32'h1000_0000 + i, 32'h2000_0000 + i, 32'h0, 1'b0);
      chk("ovf_before_9th", {31'd0, overflow}, 32'd0);
      send_req(32'h1000_0009, 32'h2000_0009, 32'h0, 1'b0);
      chk("ovf_after_9th", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         send_rsp(32'h3000_0000 + i, 5'h02, 32'h3000_0000 + i);
         wait_drain(40);
      end
      chk("ovf_rec_count", {16'd0, rec_count}, 32'd13);
      chk("ovf_no_orphan", {31'd0, orphan}, 32'd0);

      // orphan response after reset
      do_reset();
      chk("reset_clears_ovf", {31'd0, overflow}, 32'd0);
      tr.rsp_ready  = 1'b1;
      tr.rsp_result = 32'h1234_5678;
      tr.rsp_flags  = 5'h1F;
      tick();
      tr.rsp_ready = 1'b0;
      chk("orphan_set", {31'd0, orphan}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("orphan_no_valid", {31'd0, tr.out_valid}, 32'd0);
      end
      chk("orphan_rec_count", {16'd0, rec_count}, 32'd0);

      // NaN result on a mul
      send_req(32'h7F80_0001, 32'h4000_0000, 32'h0, 1'b0);
      repeat (2) tick();
      send_rsp(32'hFFC1_2345, 5'h10, nan_exp);
      wait_drain(20);
      chk("nan_rec_count", {16'd0, rec_count}, 32'd1);

      // reset while the result word is on the bus
      send_req(32'h4100_0000, 32'h4110_0000, 32'h0, 1'b0);
      tick();
      send_rsp(32'h4188_0000, 5'h00, 32'h4188_0000);
      begin
         int n = 0;
         while (!(tr.out_valid === 1'b1 && tr.out_data === 32'h4188_0000) && n < 20) begin
            tick();
            n++;
         end
         chk("reach_w_res", (n < 20) ? 32'd1 : 32'd0, 32'd1);
      end
      reset = 1'b0;
      tick();
      chk("midrst_valid", {31'd0, tr.out_valid}, 32'd0);
      chk("midrst_rec_count", {16'd0, rec_count}, 32'd0);
      reset = 1'b1;
      sb.delete();
      mq.delete();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst_stays_idle", {31'd0, tr.out_valid}, 32'd0);
      end
      send_req(32'h4120_0000, 32'h4130_0000, 32'h0, 1'b0);
      tick();
      send_rsp(32'h41A8_0000, 5'h04, 32'h41A8_0000);
      wait_drain(20);
      chk("post_rst_rec_count", {16'd0, rec_count}, 32'd1);
      chk("post_rst_orphan", {31'd0, orphan}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_trace_writer.md
Name: fp_trace_writer

Overview:
- Transmit-side counterpart to the FP vector checker: observes fp_unit request/response traffic and serialises each completed operation into the 32-bit hex-record word stream the vector checker consumes.
- Sits beside fp_unit, snooping fp_exe_i and fp_exe_o; output goes to a trace sink (file dumper or debug FIFO).
- Record format: mulAdd = data1, data2, data3, result, flags (5 words); add/sub/mul = data1, data2, result, flags (4 words).

Parameters:
REQ_DEPTH, 8, request-tracking FIFO entries (power of 2)
REC_DEPTH, 4, completed-record FIFO entries (power of 2)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
req_enable  in  1  request issued to fp_unit this cycle
req_data1  in  32  operand A
req_data2  in  32  operand B
req_data3  in  32  operand C (used only when req_fmadd=1)
req_fmadd  in  1  1 = 5-word record, 0 = 4-word record
rsp_ready  in  1  fp_unit result valid this cycle
rsp_result  in  32  fp_unit result
rsp_flags  in  5  fp_unit exception flags
out_valid  out  1  out_data valid
out_data  out  32  record word
out_last  out  1  high on the flags word of each record
out_ready  in  1  sink accepts word
overflow  out  1  sticky: request or record dropped
orphan  out  1  sticky: rsp_ready with no outstanding request
rec_count  out  16  records fully emitted, wraps modulo 2^16

Behaviour:
- Reset (reset=0 at posedge): both FIFOs empty, FSM IDLE; out_valid, out_data, out_last, overflow, orphan, rec_count all 0. Reset mid-record abandons it with no partial completion.
- Request FIFO:
  - req_enable=1 pushes {data1, data2, data3, fmadd}.
  - If full: entry is dropped and overflow set.
- Response matching (in order):
  - rsp_ready=1 pops the request FIFO head and pushes {head, rsp_result, rsp_flags} into the record FIFO at the next edge.
  - If the request FIFO is empty at that edge: orphan set, nothing pushed.
  - Enable and ready in the same cycle: push and pop both occur. A same-cycle request never matches its own response (zero latency unsupported).
  - If the record FIFO is full when a response arrives: record dropped, request entry still popped, overflow set.
- Latency: rsp_ready at cycle t → record in FIFO after edge t → out_valid=1 with data1 from edge t+1 when FSM is IDLE.
- Serializer FSM states: IDLE, W_D1, W_D2, W_D3, W_RES, W_FLG.
  - IDLE → W_D1 when the record FIFO is non-empty.
  - A word advances only on out_valid & out_ready.
  - W_D1 → W_D2.
  - W_D2 → W_D3 if fmadd, else → W_RES.
  - W_D3 → W_RES → W_FLG.
  - W_FLG accept: pop record, increment rec_count. Go to W_D1 if another record is pending (no bubble), else IDLE.
- Flags word is {27'b0, flags}; out_last=1 only in W_FLG.
- out_data and out_last hold stable while out_valid & !out_ready.
- out_valid=0 only in IDLE.

Optional Feature:
- Macro FP_TRACE_NAN_CANON_EN.
  - Defined: any result with bits[30:23]=8'hFF and bits[22:0]≠0 is emitted as 32'h7FC00000, regardless of sign or payload. Flags word is unaffected.
  - Undefined: result emitted raw.

Test Plan:
- add request A=3F800000, B=40000000; ready 3 cycles later with result 40400000, flags 0; out_ready=1 → words 3F800000, 40000000, 40400000, 00000000 on consecutive cycles, out_last on the 4th, rec_count=1.
- fmadd A=3F800000, B=3F800000, C=3F800000 → result 40000000, flags 01 → 5 words, last word 00000001, out_last only on it.
- 3 back-to-back add requests, 3 back-to-back responses, out_ready toggling 1,0,1,0 → 12 words in order, each held through the stall cycles, rec_count=3, no idle gap between records while out_ready=1.
- 9 requests with REQ_DEPTH=8 and no responses → overflow=1 after the 9th. 8 responses then yield 8 records with operands of requests 1–8.
- rsp_ready after reset with no request → orphan=1, out_valid stays 0, rec_count=0.
- With FP_TRACE_NAN_CANON_EN, mul response FFC12345 → result word 7FC00000. Without the macro → FFC12345.
- reset=0 asserted during the W_RES word → next cycle out_valid=0, rec_count=0, FIFOs empty.
